// File: rtl/transducer_burst_array.sv
// transducer_burst_array
//   Multi-channel transducer pulse output stage. After arming (onYourMark),
//   a fire trigger starts a burst on every enabled channel: each channel
//   waits its own phase delay, then emits pulseCount pulses of its own
//   charge time separated by a shared rest time. A per-channel watchdog cuts
//   a channel off after DANGER_MAX consecutive high cycles and sets a sticky
//   warning bit.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   isActive          block enable; low aborts and clears synchronously
//   chanEnable        per-channel enable, latched at arm
//   onYourMark        arm request, latches the configuration
//   fire              fire trigger (honoured only in ARMED)
//   phaseDelay        per-channel delay, channel i at [i*PD_W +: PD_W]
//   chargeTime        per-channel pulse high time, channel i at [i*CT_W +: CT_W]
//   restTime          shared low time between pulses
//   pulseCount        pulses per burst
//   clearWarning      clears all warning bits
//   transducerOutput  registered drive outputs
//   fireComplete      high when idle
//   doneStrobe        one-cycle pulse when a burst ends normally
//   busy              high while ARMED or FIRING
//   warning           sticky per-channel watchdog trip
module transducer_burst_array #(
  parameter int NCH        = 8,
  parameter int PD_W       = 16,
  parameter int CT_W       = 9,
  parameter int NP_W       = 8,
  parameter int DANGER_MAX = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 isActive,
  input  logic [NCH-1:0]       chanEnable,
  input  logic                 onYourMark,
  input  logic                 fire,
  input  logic [NCH*PD_W-1:0]  phaseDelay,
  input  logic [NCH*CT_W-1:0]  chargeTime,
  input  logic [CT_W-1:0]      restTime,
  input  logic [NP_W-1:0]      pulseCount,
  input  logic                 clearWarning,
  output logic [NCH-1:0]       transducerOutput,
  output logic                 fireComplete,
  output logic                 doneStrobe,
  output logic                 busy,
  output logic [NCH-1:0]       warning
);

  // One counter serves delay, charge and rest phases, so it must hold the wider field.
  localparam int CNT_W = (PD_W > CT_W) ? PD_W : CT_W;
  // The watchdog counter holds completed high cycles; the cycle in which it
  // already shows DANGER_MAX-1 is the DANGER_MAX-th high cycle.
  localparam logic [CT_W-1:0] WD_LAST = CT_W'(DANGER_MAX - 1);

  typedef enum logic [1:0] {IDLE, ARMED, FIRING} stateT;
  typedef enum logic [1:0] {DELAY, CHARGE, REST, FINISHED} chStateT;

  stateT   state, stateNext;
  chStateT chState [NCH];
  chStateT chStateNext [NCH];

  logic [CNT_W-1:0] cnt [NCH];
  logic [CNT_W-1:0] cntNext [NCH];
  logic [NP_W-1:0]  pulsesLeft [NCH];
  logic [NP_W-1:0]  pulsesNext [NCH];
  logic [CT_W-1:0]  wd [NCH];
  logic [CT_W-1:0]  wdNext [NCH];

  logic [NCH-1:0]      outNext, tripNext, finNext;
  logic [NCH-1:0]      enL;
  logic [NCH*PD_W-1:0] pdL;
  logic [NCH*CT_W-1:0] ctL;
  logic [CT_W-1:0]     restL;
  logic [NP_W-1:0]     npL;
  logic                doneNext, busyNext, latchCfg, startBurst;

  assign latchCfg   = isActive && onYourMark && (state == IDLE || state == ARMED);
  assign startBurst = isActive && (state == ARMED) && fire && !onYourMark;

  // Configuration is captured only while idle or armed, so input changes
  // during a burst cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enL   <= '0;
      pdL   <= '0;
      ctL   <= '0;
      restL <= '0;
      npL   <= '0;
    end else if (latchCfg) begin
      enL   <= chanEnable;
      pdL   <= phaseDelay;
      ctL   <= chargeTime;
      restL <= restTime;
      npL   <= pulseCount;
    end
  end

  // Per-channel sequencing. pulsesLeft counts pulses still to come after the
  // current one, so reaching the end of a charge with zero left means no
  // trailing rest. The watchdog check overrides the normal sequence.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      chStateNext[i] = chState[i];
      cntNext[i]     = cnt[i];
      pulsesNext[i]  = pulsesLeft[i];
      outNext[i]     = transducerOutput[i];
      tripNext[i]    = 1'b0;
      wdNext[i]      = '0;
      if (!isActive) begin
        chStateNext[i] = FINISHED;
        cntNext[i]     = '0;
        pulsesNext[i]  = '0;
        outNext[i]     = 1'b0;
      end else if (startBurst) begin
        outNext[i] = 1'b0;
        if (!enL[i] || ctL[i*CT_W +: CT_W] == '0 || npL == '0) begin
          chStateNext[i] = FINISHED;
          cntNext[i]     = '0;
          pulsesNext[i]  = '0;
        end else begin
          chStateNext[i] = DELAY;
          cntNext[i]     = CNT_W'(pdL[i*PD_W +: PD_W]);
          pulsesNext[i]  = npL - NP_W'(1);
        end
      end else if (state == FIRING) begin
        wdNext[i] = transducerOutput[i] ? ((wd[i] == '1) ? wd[i] : wd[i] + CT_W'(1)) : '0;
        case (chState[i])
          DELAY: begin
            if (cnt[i] == '0) begin
              chStateNext[i] = CHARGE;
              outNext[i]     = 1'b1;
              cntNext[i]     = CNT_W'(ctL[i*CT_W +: CT_W]) - CNT_W'(1);
            end else begin
              cntNext[i] = cnt[i] - CNT_W'(1);
            end
          end
          CHARGE: begin
            if (cnt[i] != '0) begin
              cntNext[i] = cnt[i] - CNT_W'(1);
            end else if (pulsesLeft[i] == '0) begin
              chStateNext[i] = FINISHED;
              outNext[i]     = 1'b0;
            end else begin
              pulsesNext[i] = pulsesLeft[i] - NP_W'(1);
              // Zero rest joins consecutive pulses into one continuous high.
              if (restL == '0) begin
                cntNext[i] = CNT_W'(ctL[i*CT_W +: CT_W]) - CNT_W'(1);
              end else begin
                chStateNext[i] = REST;
                outNext[i]     = 1'b0;
                cntNext[i]     = CNT_W'(restL) - CNT_W'(1);
              end
            end
          end
          REST: begin
            if (cnt[i] == '0) begin
              chStateNext[i] = CHARGE;
              outNext[i]     = 1'b1;
              cntNext[i]     = CNT_W'(ctL[i*CT_W +: CT_W]) - CNT_W'(1);
            end else begin
              cntNext[i] = cnt[i] - CNT_W'(1);
            end
          end
          default: begin
            outNext[i] = 1'b0;
          end
        endcase
        if (transducerOutput[i] && wd[i] >= WD_LAST) begin
          chStateNext[i] = FINISHED;
          outNext[i]     = 1'b0;
          cntNext[i]     = '0;
          pulsesNext[i]  = '0;
          tripNext[i]    = 1'b1;
        end
      end else begin
        chStateNext[i] = FINISHED;
        cntNext[i]     = '0;
        pulsesNext[i]  = '0;
        outNext[i]     = 1'b0;
      end
      finNext[i] = (chStateNext[i] == FINISHED);
    end
  end

  // Channel state, counters and drive outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        chState[i]    <= FINISHED;
        cnt[i]        <= '0;
        pulsesLeft[i] <= '0;
        wd[i]         <= '0;
      end
      transducerOutput <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        chState[i]    <= chStateNext[i];
        cnt[i]        <= cntNext[i];
        pulsesLeft[i] <= pulsesNext[i];
        wd[i]         <= wdNext[i];
      end
      transducerOutput <= outNext;
    end
  end

  // Global state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Global next state. FIRING ends on the same edge the last channel's
  // output falls, which is why it looks at the channels' next states.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (onYourMark) stateNext = ARMED;
      ARMED:   if (fire && !onYourMark) stateNext = FIRING;
      FIRING:  if (&finNext) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (!isActive) stateNext = IDLE;
  end

  // Global output decode, registered below.
  always_comb begin
    doneNext = isActive && (state == FIRING) && (&finNext);
    busyNext = (stateNext != IDLE);
  end

  // Status outputs and sticky warnings; a trip on the same edge as
  // clearWarning still leaves its bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      fireComplete <= 1'b1;
      doneStrobe   <= 1'b0;
      warning      <= '0;
    end else begin
      busy         <= busyNext;
      fireComplete <= !busyNext;
      doneStrobe   <= doneNext;
      if (!isActive) warning <= '0;
      else           warning <= (warning & ~{NCH{clearWarning}}) | tripNext;
    end
  end

endmodule

// File: tb/tb_transducer_burst_array.sv
// tb_transducer_burst_array
//   Scoreboard bench for transducer_burst_array. Each burst is predicted
//   from its timing rules (rise at fire edge + 1 + delay, period of charge
//   plus rest, watchdog after DANGER_MAX consecutive high cycles) into
//   per-edge expectation tables and a done queue; a monitor compares the
//   DUT every cycle and pops the done queue on each doneStrobe.
module tb_transducer_burst_array;

  localparam int NCH  = 4;
  localparam int PD_W = 16;
  localparam int CT_W = 9;
  localparam int NP_W = 8;
  localparam int DMAX = 500;
  localparam int PDB  = NCH * PD_W;
  localparam int CTB  = NCH * CT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             isActive;
  logic [NCH-1:0]   chanEnable;
  logic             onYourMark;
  logic             fire;
  logic [PDB-1:0]   phaseDelay;
  logic [CTB-1:0]   chargeTime;
  logic [CT_W-1:0]  restTime;
  logic [NP_W-1:0]  pulseCount;
  logic             clearWarning;
  logic [NCH-1:0]   transducerOutput;
  logic             fireComplete;
  logic             doneStrobe;
  logic             busy;
  logic [NCH-1:0]   warning;

  transducer_burst_array #(
    .NCH(NCH), .PD_W(PD_W), .CT_W(CT_W), .NP_W(NP_W), .DANGER_MAX(DMAX)
  ) dut (
    .clk(clk), .rst(rst), .isActive(isActive), .chanEnable(chanEnable),
    .onYourMark(onYourMark), .fire(fire), .phaseDelay(phaseDelay),
    .chargeTime(chargeTime), .restTime(restTime), .pulseCount(pulseCount),
    .clearWarning(clearWarning), .transducerOutput(transducerOutput),
    .fireComplete(fireComplete), .doneStrobe(doneStrobe), .busy(busy),
    .warning(warning)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen; the cycle after edge e is sampled while it reads e.
  int edgeCount = 0;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  typedef struct {
    int             atEdge;
    logic [NCH-1:0] warn;
  } doneT;

  doneT           doneQ[$];
  logic [NCH-1:0] expOut[int];
  bit             expBusy[int];
  logic [NCH-1:0] modelWarn = '0;
  logic [NCH-1:0] pendingTrips = '0;
  int             checks = 0;
  int             errors = 0;

  int             pdC[NCH];
  int             ctC[NCH];
  int             restC;
  int             npC;
  logic [NCH-1:0] enC;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeCount, actual, expected);
    end
  endtask

  // Monitor: per-cycle output/status comparison and done-queue scoreboard.
  always @(negedge clk) begin
    logic [NCH-1:0] eo;
    bit             eb;
    doneT           d;
    eo = expOut.exists(edgeCount) ? expOut[edgeCount] : '0;
    eb = expBusy.exists(edgeCount) ? expBusy[edgeCount] : 1'b0;
    checkOutput("transducerOutput", 32'(transducerOutput), 32'(eo));
    checkOutput("busy", 32'(busy), 32'(eb));
    checkOutput("fireComplete", 32'(fireComplete), 32'(!eb));
    if (doneStrobe) begin
      if (doneQ.size() > 0) begin
        d = doneQ.pop_front();
        checkOutput("doneEdge", 32'(edgeCount), 32'(d.atEdge));
        checkOutput("warningAtDone", 32'(warning), 32'(d.warn));
      end else begin
        checkOutput("spuriousDone", 32'(doneStrobe), 32'(0));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic setHigh(input int e, input int ch);
    logic [NCH-1:0] v;
    v = expOut.exists(e) ? expOut[e] : '0;
    v[ch] = 1'b1;
    expOut[e] = v;
  endtask

  // Reference model: for fire sampled at edge k, mark every high cycle of
  // every channel and return the edge on which the burst completes.
  task automatic buildModel(input int k, output int doneEdge, output logic [NCH-1:0] trips);
    int period, first, last, streak, lastHigh, t;
    bit tripped, high;
    doneEdge = k + 1;
    trips    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (enC[i] && ctC[i] > 0 && npC > 0) begin
        period   = ctC[i] + restC;
        first    = k + 1 + pdC[i];
        last     = first + npC * period;
        streak   = 0;
        lastHigh = first;
        tripped  = 1'b0;
        for (int e = first; e < last; e++) begin
          t    = e - first;
          high = !tripped && (t / period < npC) && (t % period < ctC[i]);
          if (high) begin
            streak++;
            lastHigh = e;
            setHigh(e, i);
            if (streak == DMAX) begin
              tripped  = 1'b1;
              trips[i] = 1'b1;
            end
          end else begin
            streak = 0;
          end
        end
        if (lastHigh + 1 > doneEdge) doneEdge = lastHigh + 1;
      end
    end
  endtask

  task automatic driveCfg();
    for (int i = 0; i < NCH; i++) begin
      phaseDelay[i*PD_W +: PD_W] = PD_W'(pdC[i]);
      chargeTime[i*CT_W +: CT_W] = CT_W'(ctC[i]);
    end
    restTime   = CT_W'(restC);
    pulseCount = NP_W'(npC);
    chanEnable = enC;
  endtask

  task automatic scrambleInputs();
    phaseDelay = PDB'({$urandom, $urandom});
    chargeTime = CTB'({$urandom, $urandom});
    restTime   = CT_W'($urandom);
    pulseCount = NP_W'($urandom);
    chanEnable = NCH'($urandom);
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (doneQ.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    if (doneQ.size() > 0) begin
      checkOutput("doneTimeout", 32'(doneQ.size()), 32'(0));
      doneQ.delete();
    end
    modelWarn    = modelWarn | pendingTrips;
    pendingTrips = '0;
  endtask

  // Drop expectations from the given edge onward (after an abort).
  task automatic truncateModel(input int fromEdge);
    int keys[$];
    foreach (expOut[key]) if (key >= fromEdge) keys.push_back(key);
    foreach (keys[j]) expOut.delete(keys[j]);
    keys.delete();
    foreach (expBusy[key]) if (key >= fromEdge) keys.push_back(key);
    foreach (keys[j]) expBusy.delete(keys[j]);
  endtask

  // Arm with the current pdC/ctC/... configuration, fire, predict, and
  // optionally wait for the burst to complete.
  task automatic applyStimulus(input bit waitForDone);
    int armEdge, k, d;
    tick();
    driveCfg();
    onYourMark = 1'b1;
    armEdge = edgeCount + 1;
    expBusy[armEdge] = 1'b1;
    tick();
    onYourMark = 1'b0;
    fire = 1'b1;
    k = edgeCount + 1;
    buildModel(k, d, pendingTrips);
    for (int e = k; e < d; e++) expBusy[e] = 1'b1;
    doneQ.push_back('{atEdge: d, warn: modelWarn | pendingTrips});
    tick();
    fire = 1'b0;
    scrambleInputs();
    if (waitForDone) waitDone(d - edgeCount + 10);
  endtask

  task automatic randomCfg();
    enC = NCH'($urandom);
    for (int i = 0; i < NCH; i++) begin
      pdC[i] = $urandom_range(0, 12);
      ctC[i] = $urandom_range(0, 6);
    end
    restC = $urandom_range(0, 3);
    npC   = $urandom_range(0, 4);
  endtask

  task automatic uniformCfg(input logic [NCH-1:0] en, input int pd, input int ct, input int rest, input int np);
    enC = en;
    for (int i = 0; i < NCH; i++) begin
      pdC[i] = pd;
      ctC[i] = ct;
    end
    restC = rest;
    npC   = np;
  endtask

  initial begin
    rst          = 1'b1;
    isActive     = 1'b1;
    chanEnable   = '0;
    onYourMark   = 1'b0;
    fire         = 1'b0;
    phaseDelay   = '0;
    chargeTime   = '0;
    restTime     = '0;
    pulseCount   = '0;
    clearWarning = 1'b0;
    tick();
    tick();
    checkOutput("resetWarning", 32'(warning), 32'(0));
    checkOutput("resetDone", 32'(doneStrobe), 32'(0));
    rst = 1'b0;

    $display("[TB] directed: staggered delays, single pulse");
    uniformCfg(4'b1111, 0, 4, 2, 1);
    pdC[1] = 3; pdC[2] = 5; pdC[3] = 10;
    applyStimulus(1'b1);

    $display("[TB] directed: three pulses with rest");
    uniformCfg(4'b0010, 0, 3, 2, 3);
    pdC[1] = 2;
    applyStimulus(1'b1);

    $display("[TB] directed: all channels disabled");
    uniformCfg(4'b0000, 4, 5, 1, 2);
    applyStimulus(1'b1);

    $display("[TB] random bursts");
    for (int n = 0; n < 20; n++) begin
      randomCfg();
      applyStimulus(1'b1);
    end

    $display("[TB] watchdog trip on channel 0");
    uniformCfg(4'b0011, 0, 300, 0, 2);
    ctC[1] = 5; pdC[1] = 4;
    applyStimulus(1'b1);
    checkOutput("warningAfterTrip", 32'(warning), 32'(modelWarn));

    $display("[TB] reset mid-burst");
    uniformCfg(4'b1111, 3, 5, 2, 4);
    applyStimulus(1'b0);
    repeat (6) tick();
    rst = 1'b1;
    expOut.delete();
    expBusy.delete();
    doneQ.delete();
    modelWarn    = '0;
    pendingTrips = '0;
    #1;
    checkOutput("rstOutput", 32'(transducerOutput), 32'(0));
    checkOutput("rstFireComplete", 32'(fireComplete), 32'(1));
    checkOutput("rstBusy", 32'(busy), 32'(0));
    checkOutput("rstWarning", 32'(warning), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    repeat (4) tick();

    $display("[TB] watchdog trip on channel 2, then clearWarning");
    uniformCfg(4'b0100, 2, 250, 0, 3);
    applyStimulus(1'b1);
    checkOutput("warningAfterTrip2", 32'(warning), 32'(modelWarn));
    clearWarning = 1'b1;
    tick();
    clearWarning = 1'b0;
    modelWarn = '0;
    checkOutput("warningCleared", 32'(warning), 32'(modelWarn));

    $display("[TB] isActive abort mid-burst");
    uniformCfg(4'b1111, 2, 4, 3, 4);
    applyStimulus(1'b0);
    repeat (5) tick();
    isActive = 1'b0;
    truncateModel(edgeCount + 1);
    doneQ.delete();
    pendingTrips = '0;
    modelWarn    = '0;
    tick();
    isActive = 1'b1;
    tick();
    onYourMark = 1'b1;
    fire       = 1'b1;
    begin
      int a;
      a = edgeCount + 1;
      expBusy[a]     = 1'b1;
      expBusy[a + 1] = 1'b1;
    end
    tick();
    onYourMark = 1'b0;
    fire       = 1'b0;
    tick();
    isActive = 1'b0;
    tick();
    isActive = 1'b1;
    repeat (3) tick();

    $display("[TB] random bursts after aborts");
    for (int n = 0; n < 8; n++) begin
      randomCfg();
      applyStimulus(1'b1);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
